// File: rtl/fi_mem_bus_model_if.sv
// Memory bus bundle between a requester (core imem/dmem port) and the
// formal memory responder. All signals are packed per channel: bit c (or
// slice c) belongs to channel c.
//
// Handshake semantics (one place, applies to every channel):
//   request : the requester raises mem_req with addr/wen/strb/wdata and must
//             hold all of them stable until mem_gnt is seen high in the same
//             cycle; req & gnt is the transfer (accept).
//   response: the responder raises mem_recv with mem_error/mem_rdata and
//             holds them stable until mem_ack is high in the same cycle;
//             recv & ack is the transfer (complete). mem_ack must only be
//             raised while mem_recv is high.
//
// Modports:
//   master : requester side (drives req/wen/strb/wdata/addr/ack)
//   slave  : responder side (drives gnt/recv/error/rdata)
interface fi_mem_bus_model_if #(
  parameter int NCH  = 2,
  parameter int XLEN = 32
);
  logic [NCH-1:0]      mem_req;
  logic [NCH-1:0]      mem_wen;
  logic [4*NCH-1:0]    mem_strb;
  logic [XLEN*NCH-1:0] mem_wdata;
  logic [XLEN*NCH-1:0] mem_addr;
  logic [NCH-1:0]      mem_gnt;
  logic [NCH-1:0]      mem_recv;
  logic [NCH-1:0]      mem_ack;
  logic [NCH-1:0]      mem_error;
  logic [XLEN*NCH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_wen, mem_strb, mem_wdata, mem_addr, mem_ack,
    input  mem_gnt, mem_recv, mem_error, mem_rdata
  );

  modport slave (
    input  mem_req, mem_wen, mem_strb, mem_wdata, mem_addr, mem_ack,
    output mem_gnt, mem_recv, mem_error, mem_rdata
  );
endinterface

// File: rtl/fi_mem_bus_model.sv
// Multi-channel formal memory responder. Per channel it tracks outstanding
// transactions in a small FIFO (wen bit per entry), turns nondeterministic
// grant/response sources into a protocol-legal bus with bounded grant and
// response latency, holds responses stable until acked, and raises a sticky
// flag when the requester breaks the handshake rules.
//
// Ports:
//   clock, reset   : clock, asynchronous active-high reset
//   bus (slave)    : req/wen/strb/wdata/addr/ack in, gnt/recv/error/rdata out
//   nd_gnt/nd_recv/nd_error/nd_rdata : nondeterministic sources per channel
//   outstanding    : per-channel FIFO occupancy, $clog2(DEPTH+1) bits each
//   protocol_err   : per-channel sticky requester-violation flag
module fi_mem_bus_model #(
  parameter int NCH           = 2,
  parameter int XLEN          = 32,
  parameter int DEPTH         = 2,
  parameter int MAX_GNT_STALL = 4,
  parameter int MAX_RSP_STALL = 4,
  parameter int ERROR_EN      = 1
) (
  input  logic                             clock,
  input  logic                             reset,
  fi_mem_bus_model_if.slave                bus,
  input  logic [NCH-1:0]                   nd_gnt,
  input  logic [NCH-1:0]                   nd_recv,
  input  logic [NCH-1:0]                   nd_error,
  input  logic [XLEN*NCH-1:0]              nd_rdata,
  output logic [NCH*$clog2(DEPTH+1)-1:0]   outstanding,
  output logic [NCH-1:0]                   protocol_err
);
  localparam int OW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int GW = $clog2(MAX_GNT_STALL + 1);
  localparam int RW = $clog2(MAX_RSP_STALL + 1);

  logic [OW-1:0]    occ_q   [NCH];
  logic [OW-1:0]    occ_d   [NCH];
  logic [PW-1:0]    wptr_q  [NCH];
  logic [PW-1:0]    wptr_d  [NCH];
  logic [PW-1:0]    rptr_q  [NCH];
  logic [PW-1:0]    rptr_d  [NCH];
  logic [DEPTH-1:0] wfifo_q [NCH];
  logic [DEPTH-1:0] wfifo_d [NCH];
  logic [GW-1:0]    gst_q   [NCH];
  logic [GW-1:0]    gst_d   [NCH];
  logic [RW-1:0]    rst_q   [NCH];
  logic [RW-1:0]    rst_d   [NCH];
  logic [XLEN-1:0]  rdata_q [NCH];
  logic [XLEN-1:0]  rdata_d [NCH];
  logic [XLEN-1:0]  paddr_q [NCH];
  logic [XLEN-1:0]  pwdata_q[NCH];
  logic [3:0]       pstrb_q [NCH];
  logic [NCH-1:0]   recv_q, recv_d, err_q, err_d, perr_q, perr_d;
  logic [NCH-1:0]   pstall_q, pstall_d, pwen_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  logic          full, gnt_c, acc, cmp, pending, head_wen, changed;
  logic [OW-1:0] remain;

  always_comb begin
    full          = 1'b0;
    gnt_c         = 1'b0;
    acc           = 1'b0;
    cmp           = 1'b0;
    pending       = 1'b0;
    head_wen      = 1'b0;
    changed       = 1'b0;
    remain        = '0;
    bus.mem_gnt   = '0;
    bus.mem_recv  = recv_q;
    bus.mem_error = err_q;
    bus.mem_rdata = '0;
    outstanding   = '0;
    protocol_err  = perr_q;
    recv_d        = recv_q;
    err_d         = err_q;
    perr_d        = perr_q;
    pstall_d      = '0;
    for (int c = 0; c < NCH; c++) begin
      full   = (occ_q[c] == OW'(DEPTH));
      // A completion this cycle never frees a slot for a same-cycle grant.
      gnt_c  = !full && (nd_gnt[c] || gst_q[c] == GW'(MAX_GNT_STALL));
      acc    = bus.mem_req[c] & gnt_c;
      cmp    = recv_q[c] & bus.mem_ack[c];
      remain = occ_q[c] - OW'(cmp);
      // An entry accepted this cycle may be answered at the next edge.
      pending = (remain != '0) || acc;

      rptr_d[c]  = cmp ? ptr_inc(rptr_q[c]) : rptr_q[c];
      wptr_d[c]  = acc ? ptr_inc(wptr_q[c]) : wptr_q[c];
      wfifo_d[c] = wfifo_q[c];
      if (acc) wfifo_d[c][wptr_q[c]] = bus.mem_wen[c];
      // Head after the pop; if nothing is left it is the entry being pushed.
      head_wen  = (remain == '0) ? bus.mem_wen[c] : wfifo_q[c][rptr_d[c]];
      occ_d[c]  = remain + OW'(acc);

      if (acc || !bus.mem_req[c]) gst_d[c] = '0;
      else if (!full && gst_q[c] != GW'(MAX_GNT_STALL)) gst_d[c] = gst_q[c] + GW'(1);
      else gst_d[c] = gst_q[c];

      rst_d[c]   = rst_q[c];
      rdata_d[c] = rdata_q[c];
      if (recv_q[c] && !bus.mem_ack[c]) begin
        recv_d[c] = 1'b1;
      end else if (pending && (nd_recv[c] || rst_q[c] == RW'(MAX_RSP_STALL))) begin
        recv_d[c]  = 1'b1;
        err_d[c]   = nd_error[c] & (ERROR_EN != 0);
        rdata_d[c] = head_wen ? '0 : nd_rdata[c*XLEN +: XLEN];
        rst_d[c]   = '0;
      end else begin
        recv_d[c] = 1'b0;
        err_d[c]  = 1'b0;
        if (pending && !recv_q[c] && rst_q[c] != RW'(MAX_RSP_STALL))
          rst_d[c] = rst_q[c] + RW'(1);
      end

      changed = (bus.mem_addr[c*XLEN +: XLEN] != paddr_q[c]) ||
                (bus.mem_wdata[c*XLEN +: XLEN] != pwdata_q[c]) ||
                (bus.mem_strb[c*4 +: 4] != pstrb_q[c]) ||
                (bus.mem_wen[c] != pwen_q[c]);
      pstall_d[c] = bus.mem_req[c] & !gnt_c;
      if ((pstall_q[c] && (!bus.mem_req[c] || changed)) ||
          (bus.mem_ack[c] && !recv_q[c]))
        perr_d[c] = 1'b1;

      bus.mem_gnt[c]                = gnt_c;
      bus.mem_rdata[c*XLEN +: XLEN] = rdata_q[c];
      outstanding[c*OW +: OW]       = occ_q[c];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      recv_q   <= '0;
      err_q    <= '0;
      perr_q   <= '0;
      pstall_q <= '0;
      pwen_q   <= '0;
      for (int c = 0; c < NCH; c++) begin
        occ_q[c]    <= '0;
        wptr_q[c]   <= '0;
        rptr_q[c]   <= '0;
        wfifo_q[c]  <= '0;
        gst_q[c]    <= '0;
        rst_q[c]    <= '0;
        rdata_q[c]  <= '0;
        paddr_q[c]  <= '0;
        pwdata_q[c] <= '0;
        pstrb_q[c]  <= '0;
      end
    end else begin
      recv_q   <= recv_d;
      err_q    <= err_d;
      perr_q   <= perr_d;
      pstall_q <= pstall_d;
      pwen_q   <= bus.mem_wen;
      for (int c = 0; c < NCH; c++) begin
        occ_q[c]    <= occ_d[c];
        wptr_q[c]   <= wptr_d[c];
        rptr_q[c]   <= rptr_d[c];
        wfifo_q[c]  <= wfifo_d[c];
        gst_q[c]    <= gst_d[c];
        rst_q[c]    <= rst_d[c];
        rdata_q[c]  <= rdata_d[c];
        paddr_q[c]  <= bus.mem_addr[c*XLEN +: XLEN];
        pwdata_q[c] <= bus.mem_wdata[c*XLEN +: XLEN];
        pstrb_q[c]  <= bus.mem_strb[c*4 +: 4];
      end
    end
  end
endmodule

// File: tb/tb_fi_mem_bus_model.sv
// Bench for fi_mem_bus_model: directed scenarios plus a randomized legal
// requester, all checked every cycle against a queue-based channel model.
// A second instance with ERROR_EN=0 sees the same stimulus.
module tb_fi_mem_bus_model;
  localparam int NCH = 2, XLEN = 32, DEPTH = 2, MAXG = 4, MAXR = 4;
  localparam int OW = $clog2(DEPTH + 1);

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [NCH-1:0]      nd_gnt, nd_recv, nd_error;
  logic [XLEN*NCH-1:0] nd_rdata;
  logic [NCH*OW-1:0]   outstanding, outstanding0;
  logic [NCH-1:0]      protocol_err, protocol_err0;

  fi_mem_bus_model_if #(.NCH(NCH), .XLEN(XLEN)) ifc ();
  fi_mem_bus_model_if #(.NCH(NCH), .XLEN(XLEN)) ifc0 ();
  assign ifc0.mem_req   = ifc.mem_req;
  assign ifc0.mem_wen   = ifc.mem_wen;
  assign ifc0.mem_strb  = ifc.mem_strb;
  assign ifc0.mem_wdata = ifc.mem_wdata;
  assign ifc0.mem_addr  = ifc.mem_addr;
  assign ifc0.mem_ack   = ifc.mem_ack;

  fi_mem_bus_model #(.NCH(NCH), .XLEN(XLEN), .DEPTH(DEPTH), .MAX_GNT_STALL(MAXG),
    .MAX_RSP_STALL(MAXR), .ERROR_EN(1)) dut (
    .clock(clock), .reset(reset), .bus(ifc), .nd_gnt(nd_gnt), .nd_recv(nd_recv),
    .nd_error(nd_error), .nd_rdata(nd_rdata), .outstanding(outstanding),
    .protocol_err(protocol_err));

  fi_mem_bus_model #(.NCH(NCH), .XLEN(XLEN), .DEPTH(DEPTH), .MAX_GNT_STALL(MAXG),
    .MAX_RSP_STALL(MAXR), .ERROR_EN(0)) dut0 (
    .clock(clock), .reset(reset), .bus(ifc0), .nd_gnt(nd_gnt), .nd_recv(nd_recv),
    .nd_error(nd_error), .nd_rdata(nd_rdata), .outstanding(outstanding0),
    .protocol_err(protocol_err0));

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Channel model: exp_q holds the wen bit of every granted, un-acked entry.
  logic            exp_q [NCH][$];
  int              m_gst [NCH];
  int              m_rst [NCH];
  bit              m_recv[NCH], m_err[NCH], m_perr[NCH], m_pstall[NCH], m_gnt[NCH];
  bit              m_pwen[NCH];
  logic [XLEN-1:0] m_rdata[NCH], m_paddr[NCH], m_pwdata[NCH];
  logic [3:0]      m_pstrb[NCH];

  // Values seen at the last sampling point, for directed checks.
  logic [NCH-1:0]  o_gnt, o_recv, o_err, o_perr, o_recv0, o_err0;
  logic [XLEN-1:0] o_rdata[NCH], o_rdata0[NCH];
  logic [OW-1:0]   o_out[NCH];

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      exp_q[c].delete();
      m_gst[c] = 0; m_rst[c] = 0; m_recv[c] = 0; m_err[c] = 0; m_perr[c] = 0;
      m_pstall[c] = 0; m_pwen[c] = 0; m_rdata[c] = '0; m_paddr[c] = '0;
      m_pwdata[c] = '0; m_pstrb[c] = '0;
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < NCH; c++) begin
      bit req, ack, wen, full, acc, cmp, pending, old_recv;
      logic [XLEN-1:0] addr, wdata;
      logic [3:0] strb;
      req   = ifc.mem_req[c];
      ack   = ifc.mem_ack[c];
      wen   = ifc.mem_wen[c];
      addr  = ifc.mem_addr[c*XLEN +: XLEN];
      wdata = ifc.mem_wdata[c*XLEN +: XLEN];
      strb  = ifc.mem_strb[c*4 +: 4];
      full  = (exp_q[c].size() == DEPTH);
      acc   = req && m_gnt[c];
      cmp   = m_recv[c] && ack;
      if (m_pstall[c] && (!req || addr != m_paddr[c] || wdata != m_pwdata[c] ||
                          strb != m_pstrb[c] || wen != m_pwen[c]))
        m_perr[c] = 1;
      if (ack && !m_recv[c]) m_perr[c] = 1;
      if (cmp) void'(exp_q[c].pop_front());
      if (acc) exp_q[c].push_back(wen);
      pending  = (exp_q[c].size() > 0);
      old_recv = m_recv[c];
      if (old_recv && !ack) begin
        // response held
      end else if (pending && (nd_recv[c] || m_rst[c] == MAXR)) begin
        m_recv[c]  = 1;
        m_err[c]   = nd_error[c];
        m_rdata[c] = exp_q[c][0] ? '0 : nd_rdata[c*XLEN +: XLEN];
        m_rst[c]   = 0;
      end else begin
        m_recv[c] = 0;
        m_err[c]  = 0;
        if (pending && !old_recv && m_rst[c] < MAXR) m_rst[c]++;
      end
      if (acc || !req) m_gst[c] = 0;
      else if (!full && m_gst[c] < MAXG) m_gst[c]++;
      m_pstall[c] = req && !m_gnt[c];
      m_paddr[c] = addr; m_pwdata[c] = wdata; m_pstrb[c] = strb; m_pwen[c] = wen;
    end
  endtask

  // One clock cycle: inputs are already applied; sample at the falling edge,
  // advance the model, then return just after the rising edge.
  task automatic cycle();
    @(negedge clock);
    for (int c = 0; c < NCH; c++) begin
      m_gnt[c] = (exp_q[c].size() < DEPTH) && (nd_gnt[c] || m_gst[c] == MAXG);
      check_val($sformatf("gnt%0d", c), ifc.mem_gnt[c], m_gnt[c]);
      check_val($sformatf("recv%0d", c), ifc.mem_recv[c], m_recv[c]);
      check_val($sformatf("outstanding%0d", c), outstanding[c*OW +: OW], exp_q[c].size());
      check_val($sformatf("perr%0d", c), protocol_err[c], m_perr[c]);
      check_val($sformatf("gnt%0d_ne", c), ifc0.mem_gnt[c], m_gnt[c]);
      check_val($sformatf("recv%0d_ne", c), ifc0.mem_recv[c], m_recv[c]);
      if (m_recv[c]) begin
        check_val($sformatf("rdata%0d", c), ifc.mem_rdata[c*XLEN +: XLEN], m_rdata[c]);
        check_val($sformatf("error%0d", c), ifc.mem_error[c], m_err[c]);
        check_val($sformatf("rdata%0d_ne", c), ifc0.mem_rdata[c*XLEN +: XLEN], m_rdata[c]);
        check_val($sformatf("error%0d_ne", c), ifc0.mem_error[c], 0);
      end
      o_rdata[c]  = ifc.mem_rdata[c*XLEN +: XLEN];
      o_rdata0[c] = ifc0.mem_rdata[c*XLEN +: XLEN];
      o_out[c]    = outstanding[c*OW +: OW];
    end
    o_gnt = ifc.mem_gnt; o_recv = ifc.mem_recv; o_err = ifc.mem_error;
    o_perr = protocol_err; o_recv0 = ifc0.mem_recv; o_err0 = ifc0.mem_error;
    model_step();
    @(posedge clock);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    ifc.mem_req = '0; ifc.mem_wen = '0; ifc.mem_strb = '0; ifc.mem_wdata = '0;
    ifc.mem_addr = '0; ifc.mem_ack = '0;
    nd_gnt = '0; nd_recv = '0; nd_error = '0; nd_rdata = '0;
  endtask

  task automatic set_req(input int c, input bit req, input logic [31:0] addr, input bit wen);
    ifc.mem_req[c] = req;
    ifc.mem_wen[c] = wen;
    ifc.mem_addr[c*XLEN +: XLEN] = addr;
    ifc.mem_strb[c*4 +: 4] = 4'hf;
    ifc.mem_wdata[c*XLEN +: XLEN] = addr ^ 32'h5a5a_0000;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    #1;
    for (int c = 0; c < NCH; c++) begin
      check_val($sformatf("rst_recv%0d", c), ifc.mem_recv[c], 0);
      check_val($sformatf("rst_error%0d", c), ifc.mem_error[c], 0);
      check_val($sformatf("rst_rdata%0d", c), ifc.mem_rdata[c*XLEN +: XLEN], 0);
      check_val($sformatf("rst_outstanding%0d", c), outstanding[c*OW +: OW], 0);
      check_val($sformatf("rst_perr%0d", c), protocol_err[c], 0);
    end
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    @(posedge clock);
    #1;
  endtask

  task automatic gen_random();
    for (int c = 0; c < NCH; c++) begin
      if (!m_pstall[c]) begin
        bit wen;
        wen = 1'($urandom_range(0, 1));
        ifc.mem_req[c] = ($urandom_range(0, 99) < 60);
        ifc.mem_wen[c] = wen;
        ifc.mem_addr[c*XLEN +: XLEN] = $urandom() & 32'hffff_fffc;
        ifc.mem_wdata[c*XLEN +: XLEN] = $urandom();
        ifc.mem_strb[c*4 +: 4] = wen ? 4'($urandom_range(1, 15)) : 4'hf;
      end
      ifc.mem_ack[c] = m_recv[c] ? 1'($urandom_range(0, 1)) : 1'b0;
      nd_gnt[c]   = ($urandom_range(0, 99) < 30);
      nd_recv[c]  = ($urandom_range(0, 99) < 40);
      nd_error[c] = ($urandom_range(0, 99) < 25);
      nd_rdata[c*XLEN +: XLEN] = $urandom();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    idle();
    model_reset();
    #1;
    do_reset();

    // Grant forced after MAX_GNT_STALL stalled request cycles.
    set_req(0, 1, 32'h100, 0);
    for (int k = 1; k <= 5; k++) begin
      cycle();
      check_val($sformatf("t1_gnt_cycle%0d", k), o_gnt[0], (k == 5) ? 1 : 0);
    end
    set_req(0, 0, 32'h100, 0);
    cycle();
    check_val("t1_outstanding", o_out[0], 1);
    do_reset();

    // Read response held stable until acked.
    set_req(0, 1, 32'h200, 0);
    nd_gnt[0] = 1; nd_recv[0] = 1; nd_rdata[31:0] = 32'hDEADBEEF;
    cycle();
    check_val("t2_gnt", o_gnt[0], 1);
    set_req(0, 0, 32'h200, 0);
    nd_gnt[0] = 0;
    for (int k = 0; k < 3; k++) begin
      nd_rdata[31:0] = $urandom();
      cycle();
      check_val("t2_recv_held", o_recv[0], 1);
      check_val("t2_rdata_held", o_rdata[0], 32'hDEADBEEF);
    end
    ifc.mem_ack[0] = 1;
    cycle();
    check_val("t2_rdata_ack", o_rdata[0], 32'hDEADBEEF);
    ifc.mem_ack[0] = 0;
    cycle();
    check_val("t2_outstanding_0", o_out[0], 0);
    check_val("t2_recv_low", o_recv[0], 0);
    do_reset();

    // FIFO full blocks the third request until a completion has retired.
    nd_gnt[0] = 1; nd_recv[0] = 1;
    set_req(0, 1, 32'h10, 0); cycle(); check_val("t3_gnt_a", o_gnt[0], 1);
    set_req(0, 1, 32'h14, 0); cycle(); check_val("t3_gnt_b", o_gnt[0], 1);
    set_req(0, 1, 32'h18, 0); cycle(); check_val("t3_gnt_full", o_gnt[0], 0);
    check_val("t3_outstanding_2", o_out[0], 2);
    ifc.mem_ack[0] = 1; cycle(); check_val("t3_gnt_full_ack", o_gnt[0], 0);
    ifc.mem_ack[0] = 0; cycle(); check_val("t3_gnt_c", o_gnt[0], 1);
    check_val("t3_outstanding_1", o_out[0], 1);
    set_req(0, 0, 32'h18, 0); cycle();
    check_val("t3_perr", o_perr[0], 0);
    do_reset();

    // Write response: zero data; error masked on the ERROR_EN=0 instance.
    set_req(0, 1, 32'h300, 1);
    nd_gnt[0] = 1; nd_recv[0] = 1; nd_error[0] = 1; nd_rdata[31:0] = 32'h1234;
    cycle();
    set_req(0, 0, 32'h300, 0);
    nd_gnt[0] = 0;
    cycle();
    check_val("t4_recv_ne", o_recv0[0], 1);
    check_val("t4_rdata_ne", o_rdata0[0], 0);
    check_val("t4_error_ne", o_err0[0], 0);
    check_val("t4_error_en", o_err[0], 1);
    check_val("t4_rdata_en", o_rdata[0], 0);
    ifc.mem_ack[0] = 1; cycle();
    ifc.mem_ack[0] = 0; cycle();
    do_reset();

    // Address change while stalled, then ack without recv: sticky flag.
    set_req(0, 1, 32'h40, 0); cycle();
    set_req(0, 1, 32'h44, 0); cycle();
    set_req(0, 0, 32'h44, 0); cycle();
    check_val("t5_perr_set", o_perr[0], 1);
    check_val("t5_perr_other_ch", o_perr[1], 0);
    ifc.mem_ack[0] = 1; cycle();
    ifc.mem_ack[0] = 0; cycle();
    check_val("t5_perr_sticky", o_perr[0], 1);
    do_reset();

    // Reset with two outstanding and a live response.
    ifc.mem_ack[0] = 1; cycle();
    ifc.mem_ack[0] = 0;
    nd_gnt[0] = 1; nd_recv[0] = 1;
    set_req(0, 1, 32'h80, 0); cycle();
    set_req(0, 1, 32'h84, 0); cycle();
    set_req(0, 0, 32'h84, 0); cycle();
    check_val("t6_outstanding_2", o_out[0], 2);
    check_val("t6_recv", o_recv[0], 1);
    check_val("t6_perr", o_perr[0], 1);
    do_reset();
    nd_recv = '1; nd_gnt = '1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check_val("t6_no_stale_recv", o_recv[0], 0);
    end
    do_reset();

    // Randomized legal requester on both channels.
    for (int n = 0; n < 2000; n++) begin
      gen_random();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
